udp_char_pingpong_buf: RTL
==========================

Name: udp_char_pingpong_buf

Overview:
- Character buffer between the UDP receive payload stream and the OSD character renderer.
- Payload bytes from a UDP packet are written into the inactive bank of a two-bank character RAM.
- A completed, error-free packet becomes visible only at the next vsync leading edge, so the OSD never shows a half-written string.
- The OSD side reads by address with 1-cycle latency and gets a frame-valid indication.

Parameters:
- ADDR_WIDTH, 11, character address width; bank depth = 2**ADDR_WIDTH.
- MAGIC, 8'h5A, required first payload byte; packets with any other first byte are dropped.
- VS_POL, 1'b1, active level of video_vsync.
- FILL_CHAR, 8'h20, byte returned for addresses at or beyond the displayed character count.

Ports:
- video_clk  in  1  sole clock; all logic runs on it.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  payload byte strobe.
- rx_data  in  8  payload byte.
- rx_last  in  1  marks the final byte of the packet; qualified by rx_valid.
- rx_err  in  1  packet error; qualified by rx_valid.
- video_vsync  in  1  frame sync from the video timing.
- ram_addr  in  ADDR_WIDTH  OSD read address.
- ram_rdata  out  8  character byte, 1-cycle latency.
- udp_rec_data_valid  out  1  level; high once at least one packet has been displayed.
- char_count  out  ADDR_WIDTH+1  number of characters in the displayed bank.
- overflow  out  1  1-cycle pulse when a packet is truncated.
- drop  out  1  1-cycle pulse when a packet is discarded.

Behaviour:
- Reset values: ram_rdata = 0, udp_rec_data_valid = 0, char_count = 0, overflow = 0, drop = 0.
- Reset internal state: disp_bank = 0, pending = 0, state = IDLE. RAM contents are not cleared.
- Reset mid-packet abandons that packet; there is no commit.
- FSM states: IDLE, PAYLOAD, DROP.
- IDLE, byte with rx_valid:
  - rx_err=1 or rx_data≠MAGIC: pulse drop; go to DROP unless rx_last, in which case stay in IDLE.
  - MAGIC with rx_last=1: commit with count 0; stay in IDLE.
  - MAGIC otherwise: clear pending, set wr_ptr = 0, go to PAYLOAD.
- PAYLOAD, each rx_valid byte:
  - If wr_ptr < 2**ADDR_WIDTH, write the byte into bank ~disp_bank at wr_ptr and increment wr_ptr.
  - Otherwise discard the byte and set the sticky trunc flag.
  - rx_err=1: pulse drop, go to DROP (or IDLE if rx_last). pending stays 0.
  - rx_last=1 with rx_err=0: commit, pulse overflow if trunc (including a truncated last byte), go to IDLE.
- DROP: wait for rx_valid & rx_last, then go to IDLE. Nothing is written or committed.
- Commit: wr_count = wr_ptr (the count after the last byte is written, if written); pending = 1 on the next cycle.
- Vsync edge detect: register video_vsync; a leading edge is the transition into the VS_POL level.
- At a leading edge with the registered pending = 1:
  - disp_bank toggles.
  - char_count = wr_count.
  - pending clears.
  - udp_rec_data_valid sets and holds high until reset.
- A commit in the same cycle as a vsync edge waits for the following edge.
- A vsync edge while in PAYLOAD has pending = 0, so there is no swap.
- A second packet arriving while pending = 1: clear pending at the magic byte and overwrite the same inactive bank; only the latest completed packet is shown.
- Read path: addr registered with the RAM read of bank disp_bank.
  - ram_rdata = RAM byte if registered addr < char_count, else FILL_CHAR.
  - Use char_count and disp_bank as they were at address sampling; after a swap, data is consistent from the next read.
- Width: wr_ptr and char_count are ADDR_WIDTH+1 bits, so a full bank (2048) is representable.
- A byte outside a packet (rx_valid in IDLE) is always treated as a packet start.

Decomposition:
- Shared package: FSM state encoding (IDLE, PAYLOAD, DROP), the MAGIC default, and the FILL_CHAR default.
- One sub-module: char_dpram, a simple dual-port RAM with one write port and one registered read port, 2*2**ADDR_WIDTH x 8. The bank select is the address MSB.

Test Plan:
- Packet 5A,'H','I',last; vsync edge → after edge char_count=2, valid=1; addr0→'H', addr1→'I', addr2→8'h20 one cycle after each address.
- Packet committed, no vsync; reads return the previous contents (after reset all 8'h20, valid=0). Then a vsync edge → new text appears.
- Packet with rx_err on its 3rd byte, then vsync → drop pulses once; no swap; char_count unchanged.
- First byte 8'h11 followed by 4 bytes, then vsync → drop pulse; no RAM write visible; display unchanged.
- Packet of 2050 payload bytes → overflow pulses at last; after vsync char_count=2048; addr 2047 holds byte #2048.
- Two completed packets "AB" then "XYZ" before a vsync; commit coincides with a vsync edge → the next-but-one edge shows "XYZ", count 3. Assert rst_n mid-packet → all outputs 0 immediately; the subsequent packet works normally.

Source files
------------

// File: rtl/udp_char_pingpong_buf_pkg.sv
// Shared FSM encoding and byte defaults for the UDP character ping-pong buffer.
package udp_char_pingpong_buf_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPayload = 2'd1,
        StDrop    = 2'd2
    } state_e;

    localparam logic [7:0] MagicDefault    = 8'h5A;
    localparam logic [7:0] FillCharDefault = 8'h20;

endpackage

// File: rtl/udp_char_pingpong_buf_char_dpram.sv
// Two-bank character store: one write port, one registered read port.
// The bank select is the address MSB.
module udp_char_pingpong_buf_char_dpram #(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_WIDTH:0] waddr_i,
    input  logic [7:0]          wdata_i,
    input  logic [ADDR_WIDTH:0] raddr_i,
    output logic [7:0]          rdata_o
);

    localparam int unsigned Depth = 2 ** (ADDR_WIDTH + 1);

    logic [7:0] mem_q [Depth];
    logic [7:0] rdata_q;

    // Contents are deliberately not reset; the reader masks by character count.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_char_pingpong_buf.sv
// UDP payload to OSD character buffer: packets fill the hidden bank and are
// swapped in at the next vsync leading edge after an error-free completion.
module udp_char_pingpong_buf
    import udp_char_pingpong_buf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter logic [7:0]  MAGIC      = MagicDefault,
    parameter logic        VS_POL     = 1'b1,
    parameter logic [7:0]  FILL_CHAR  = FillCharDefault
) (
    input  logic                  video_clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_last,
    input  logic                  rx_err,
    input  logic                  video_vsync,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_rdata,
    output logic                  udp_rec_data_valid,
    output logic [ADDR_WIDTH:0]   char_count,
    output logic                  overflow,
    output logic                  drop
);

    state_e state_q, state_d;

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] wr_count_q, wr_count_d;
    logic [ADDR_WIDTH:0] char_count_q, char_count_d;
    logic                trunc_q, trunc_d;
    logic                pending_q, pending_d;
    logic                disp_bank_q, disp_bank_d;
    logic                valid_q, valid_d;
    logic                drop_q, drop_d;
    logic                ovf_q, ovf_d;
    logic                vs_q;
    logic                rd_vld_q;
    logic                rd_in_range_q;

    logic                commit;
    logic                clr_pending;
    logic                wr_en;
    logic                full;
    logic                vs_edge;
    logic                swap;
    logic [ADDR_WIDTH:0] wr_addr;
    logic [ADDR_WIDTH:0] rd_addr;
    logic [7:0]          ram_dout;

    assign full = wr_ptr_q[ADDR_WIDTH];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_count_d  = wr_count_q;
        trunc_d     = trunc_q;
        drop_d      = 1'b0;
        ovf_d       = 1'b0;
        commit      = 1'b0;
        clr_pending = 1'b0;
        wr_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_err || (rx_data != MAGIC)) begin
                        drop_d = 1'b1;
                        if (!rx_last) begin
                            state_d = StDrop;
                        end
                    end else if (rx_last) begin
                        commit     = 1'b1;
                        wr_count_d = '0;
                    end else begin
                        clr_pending = 1'b1;
                        wr_ptr_d    = '0;
                        trunc_d     = 1'b0;
                        state_d     = StPayload;
                    end
                end
            end
            StPayload: begin
                if (rx_valid) begin
                    if (!full) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (rx_err) begin
                        drop_d  = 1'b1;
                        state_d = rx_last ? StIdle : StDrop;
                    end else if (rx_last) begin
                        // trunc_d already includes a discarded final byte
                        commit     = 1'b1;
                        wr_count_d = wr_ptr_d;
                        ovf_d      = trunc_d;
                        state_d    = StIdle;
                    end
                end
            end
            StDrop: begin
                if (rx_valid && rx_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Swap uses the registered pending flag, so a commit coinciding with an
    // edge is held for the following edge.
    assign vs_edge = (video_vsync == VS_POL) && (vs_q != VS_POL);
    assign swap    = vs_edge && pending_q;

    always_comb begin
        pending_d    = pending_q;
        disp_bank_d  = disp_bank_q;
        char_count_d = char_count_q;
        valid_d      = valid_q;
        if (swap) begin
            pending_d    = 1'b0;
            disp_bank_d  = ~disp_bank_q;
            char_count_d = wr_count_q;
            valid_d      = 1'b1;
        end
        if (clr_pending) begin
            pending_d = 1'b0;
        end
        if (commit) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            wr_count_q    <= '0;
            char_count_q  <= '0;
            trunc_q       <= 1'b0;
            pending_q     <= 1'b0;
            disp_bank_q   <= 1'b0;
            valid_q       <= 1'b0;
            drop_q        <= 1'b0;
            ovf_q         <= 1'b0;
            vs_q          <= ~VS_POL;
            rd_vld_q      <= 1'b0;
            rd_in_range_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_count_q    <= wr_count_d;
            char_count_q  <= char_count_d;
            trunc_q       <= trunc_d;
            pending_q     <= pending_d;
            disp_bank_q   <= disp_bank_d;
            valid_q       <= valid_d;
            drop_q        <= drop_d;
            ovf_q         <= ovf_d;
            vs_q          <= video_vsync;
            rd_vld_q      <= 1'b1;
            rd_in_range_q <= ({1'b0, ram_addr} < char_count_q);
        end
    end

    assign wr_addr = {~disp_bank_q, wr_ptr_q[ADDR_WIDTH-1:0]};
    assign rd_addr = {disp_bank_q, ram_addr};

    udp_char_pingpong_buf_char_dpram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_char_dpram (
        .clk_i   (video_clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (rx_data),
        .raddr_i (rd_addr),
        .rdata_o (ram_dout)
    );

    // Bank and count are captured alongside the address, so a read never
    // mixes pre- and post-swap state.
    always_comb begin
        ram_rdata = '0;
        if (rd_vld_q) begin
            ram_rdata = rd_in_range_q ? ram_dout : FILL_CHAR;
        end
    end

    assign udp_rec_data_valid = valid_q;
    assign char_count         = char_count_q;
    assign overflow           = ovf_q;
    assign drop               = drop_q;

endmodule
